// File: rtl/div_pkg.sv
// Shared definitions for the signed sequential divider: FSM state
// encoding and the helper used to size the iteration counter.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Ceiling log2. Sizes a counter that must hold values up to value-1.
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Request/response bundle of the signed sequential divider.
//
// Handshake: the requester raises start with dividend/divisor valid. The
// request is taken on a rising edge only while ready=1; a start seen while
// ready=0 is dropped and never queued. Operands need only be stable on the
// accepting edge. done is a one-cycle pulse; quotient, remainder,
// div_by_zero and overflow are valid from that cycle and hold until the
// next done. ready rises again in the done cycle, so a new start may be
// presented there.
interface signed_seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_restoring_step.sv
// One restoring-division step on unsigned magnitudes: shift the partial
// remainder/quotient pair left, trial-subtract the divisor, and keep the
// difference only when it is non-negative.
module div_restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift in the quotient MSB, subtract, and restore on a negative trial.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, dmag};
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider with truncating (round-toward-zero)
// semantics. Operates on magnitudes over WIDTH restoring steps, then fixes
// up signs. Latency from accepted start to done is WIDTH+2 cycles for every
// operand pair, including divide-by-zero and the single overflow case.
module signed_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  signed_seq_divider_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dmag_r;
  logic             q_sign;
  logic             r_sign;
  logic             dz_r;
  logic             ov_r;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_out;
  logic             ov_out;
  logic             done_r;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dmag     (dmag_r),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and request acceptance.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_ITER;
        end
      end
      S_ITER: begin
        if (count == '0) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, restoring iterations and sign fix-up into the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dmag_r      <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_out      <= 1'b0;
      ov_out      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        r_sign <= bus.dividend[WIDTH-1];
        q_sign <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        quo_r  <= mag(bus.dividend);
        dmag_r <= mag(bus.divisor);
        rem_r  <= '0;
        count  <= CW'(WIDTH - 1);
        dz_r   <= (bus.divisor == '0);
        ov_r   <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
      end
      if (state == S_ITER) begin
        rem_r <= rem_next;
        quo_r <= quo_next;
        count <= count - 1'b1;
      end
      if (state == S_FIX) begin
        // Divide-by-zero forces -1; the remainder path already yields the
        // dividend because every trial subtraction of zero succeeds.
        if (dz_r)        quotient_r <= '1;
        else if (q_sign) quotient_r <= ~quo_r + 1'b1;
        else             quotient_r <= quo_r;
        remainder_r <= r_sign ? (~rem_r[WIDTH-1:0] + 1'b1) : rem_r[WIDTH-1:0];
        dz_out      <= dz_r;
        ov_out      <= ov_r;
        done_r      <= 1'b1;
      end
    end
  end

  assign bus.ready       = (state == S_IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_out;
  assign bus.overflow    = ov_out;
  assign dbg_state       = state;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for the signed sequential divider: directed WIDTH=8 vectors with
// hand-computed results, handshake and reset cases, and a full WIDTH=4
// operand sweep against a truncating-division model.
module tb_signed_seq_divider;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  signed_seq_divider_if #(.WIDTH(8)) bus8 ();
  signed_seq_divider_if #(.WIDTH(4)) bus4 ();
  logic [1:0] st8;
  logic [1:0] st4;

  signed_seq_divider #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8.slave),
    .dbg_state (st8)
  );

  signed_seq_divider #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4.slave),
    .dbg_state (st4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] e8_q[$];
  logic [7:0] e8_r[$];
  logic [1:0] e8_f[$];   // {div_by_zero, overflow}
  int         e8_c[$];
  logic [3:0] e4_q[$];
  logic [3:0] e4_r[$];
  logic [1:0] e4_f[$];
  int         e4_c[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus8.done) begin
      if (e8_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w8_spurious_done: done=1 at cycle %0d expected 0", cyc);
      end else begin
        check("w8_quotient",  bus8.quotient,  e8_q.pop_front());
        check("w8_remainder", bus8.remainder, e8_r.pop_front());
        check("w8_flags", {bus8.div_by_zero, bus8.overflow}, e8_f.pop_front());
        check("w8_done_cycle", cyc, e8_c.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.done) begin
      if (e4_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w4_spurious_done: done=1 at cycle %0d expected 0", cyc);
      end else begin
        check("w4_quotient",  bus4.quotient,  e4_q.pop_front());
        check("w4_remainder", bus4.remainder, e4_r.pop_front());
        check("w4_flags", {bus4.div_by_zero, bus4.overflow}, e4_f.pop_front());
        check("w4_done_cycle", cyc, e4_c.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_ready8();
    int n = 0;
    while (!bus8.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w8_ready_timeout: ready=0 after 40 cycles expected 1");
    end
  endtask

  task automatic wait_ready4();
    int n = 0;
    while (!bus4.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus4.ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w4_ready_timeout: ready=0 after 40 cycles expected 1");
    end
  endtask

  // Issue one WIDTH=8 request; push the hand-computed result when asked.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit push,
                     input logic [7:0] q, input logic [7:0] r, input logic [1:0] f);
    wait_ready8();
    bus8.start    = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    if (push) begin
      e8_q.push_back(q);
      e8_r.push_back(r);
      e8_f.push_back(f);
      e8_c.push_back(cyc + 10);
    end
    @(negedge clk);
    bus8.start    = 1'b0;
    bus8.dividend = 8'($urandom);
    bus8.divisor  = 8'($urandom);
  endtask

  // Issue one WIDTH=4 request with its expected result from the model.
  task automatic go4(input int a, input int b);
    int q;
    int r;
    logic [1:0] f;
    if (b == 0) begin
      q = -1; r = a; f = 2'b10;
    end else if (a == -8 && b == -1) begin
      q = -8; r = 0; f = 2'b01;
    end else begin
      q = a / b; r = a % b; f = 2'b00;
    end
    wait_ready4();
    bus4.start    = 1'b1;
    bus4.dividend = 4'(a);
    bus4.divisor  = 4'(b);
    e4_q.push_back(4'(q));
    e4_r.push_back(4'(r));
    e4_f.push_back(f);
    e4_c.push_back(cyc + 6);
    @(negedge clk);
    bus4.start    = 1'b0;
    bus4.dividend = 4'($urandom);
    bus4.divisor  = 4'($urandom);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((e8_q.size() != 0 || e4_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (e8_q.size() != 0 || e4_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding expected 0/0",
               e8_q.size(), e4_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
    bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_ready",     bus8.ready, 1);
    check("reset_done",      bus8.done, 0);
    check("reset_quotient",  bus8.quotient, 0);
    check("reset_remainder", bus8.remainder, 0);
    check("reset_flags", {bus8.div_by_zero, bus8.overflow}, 0);
    check("reset_state",     st8, 0);
    rst = 1'b0;
    @(negedge clk);

    // Signed quadrants of 100 / 7.
    go8(8'd100,  8'd7,   1, 8'h0E, 8'h02, 2'b00);
    go8(-8'sd100, 8'd7,  1, 8'hF2, 8'hFE, 2'b00);
    go8(8'd100,  -8'sd7, 1, 8'hF2, 8'h02, 2'b00);
    go8(-8'sd100, -8'sd7, 1, 8'h0E, 8'hFE, 2'b00);
    // Special cases, then a normal op that must clear the flags.
    go8(8'h80, 8'hFF, 1, 8'h80, 8'h00, 2'b01);
    go8(8'd37, 8'd0,  1, 8'hFF, 8'h25, 2'b10);
    go8(8'd6,  8'd3,  1, 8'h02, 8'h00, 2'b00);
    drain(40);

    // Start while busy is ignored; next start lands in the done cycle.
    wait_ready8();
    c0 = cyc;
    go8(8'd50, 8'd5, 1, 8'h0A, 8'h00, 2'b00);
    while (cyc < c0 + 3) @(negedge clk);
    check("busy_ready", bus8.ready, 0);
    check("busy_state", st8, 1);
    bus8.start = 1'b1; bus8.dividend = 8'd9; bus8.divisor = 8'd2;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.dividend = 8'd9; bus8.divisor = 8'd2;
    @(negedge clk);
    bus8.start = 1'b0;
    go8(8'd9, 8'd2, 1, 8'h04, 8'h01, 2'b00);
    check("b2b_start_cycle", cyc, c0 + 11);
    drain(40);

    // Reset mid-operation: outputs clear, no done pulse follows.
    wait_ready8();
    c0 = cyc;
    go8(8'd100, 8'd7, 0, 8'h00, 8'h00, 2'b00);
    while (cyc < c0 + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready",     bus8.ready, 1);
    check("midrst_done",      bus8.done, 0);
    check("midrst_quotient",  bus8.quotient, 0);
    check("midrst_remainder", bus8.remainder, 0);
    check("midrst_flags", {bus8.div_by_zero, bus8.overflow}, 0);
    repeat (15) @(negedge clk);

    // Exhaustive WIDTH=4 sweep, issued back to back.
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        go4(a, b);
      end
    end
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
